// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: point/match winner and game phase.
package tug_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } winner_t;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/tug_field_key_edge.sv
// Rising-edge detector for one synchronised key; the history bit clears on reset
// so a key held through reset produces an edge right after it.
module key_edge (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clock) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: one lit position pulled by two keys, point hold,
// scoring and end of match. Every output is registered.
module tug_field
  import tug_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_SCORE   = 7
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           L,
  input  logic                           R,
  output logic [N_LIGHTS-1:0]            lights,
  output logic [1:0]                     winner,
  output logic [$clog2(MAX_SCORE+1)-1:0] left_score,
  output logic [$clog2(MAX_SCORE+1)-1:0] right_score,
  output logic                           match_over
);

  localparam int SCORE_W = $clog2(MAX_SCORE + 1);
  localparam int POS_W   = $clog2(N_LIGHTS);
  localparam int CNT_W   = $clog2(HOLD_CYCLES + 1);
  localparam int CENTER  = (N_LIGHTS - 1) / 2;

  localparam logic [POS_W-1:0]   POS_C    = POS_W'(CENTER);
  localparam logic [POS_W-1:0]   POS_LEFT = POS_W'(N_LIGHTS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MX = SCORE_W'(MAX_SCORE);

  // Score increment that can never pass the match limit.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s >= SCORE_MX) return SCORE_MX;
    return s + SCORE_W'(1);
  endfunction

  function automatic logic [N_LIGHTS-1:0] decode(input logic [POS_W-1:0] p);
    return N_LIGHTS'(1) << p;
  endfunction

  logic le, re;

  key_edge u_left (.clock(clock), .reset(reset), .in(L), .rise(le));
  key_edge u_right(.clock(clock), .reset(reset), .in(R), .rise(re));

  state_t               state_q, state_n;
  winner_t              win_q,   win_n;
  logic [POS_W-1:0]     pos_q,   pos_n;
  logic [CNT_W-1:0]     cnt_q,   cnt_n;
  logic [SCORE_W-1:0]   ls_q,    ls_n;
  logic [SCORE_W-1:0]   rs_q,    rs_n;
  logic [N_LIGHTS-1:0]  lights_q;
  logic                 over_q;
  logic [SCORE_W-1:0]   win_score;

  assign win_score = (win_q == LEFT) ? ls_q : rs_q;

  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    pos_n   = pos_q;
    cnt_n   = cnt_q;
    ls_n    = ls_q;
    rs_n    = rs_q;
    unique case (state_q)
      PLAY: begin
        if (le && !re) begin
          if (pos_q == POS_LEFT) begin
            win_n   = LEFT;
            ls_n    = sat_inc(ls_q);
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            pos_n = pos_q + POS_W'(1);
          end
        end else if (re && !le) begin
          if (pos_q == '0) begin
            win_n   = RIGHT;
            rs_n    = sat_inc(rs_q);
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            pos_n = pos_q - POS_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          if (win_score == SCORE_MX) begin
            state_n = OVER;
          end else begin
            state_n = PLAY;
            pos_n   = POS_C;
            win_n   = NONE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      OVER: ;
      default: state_n = PLAY;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= PLAY;
      win_q    <= NONE;
      pos_q    <= POS_C;
      cnt_q    <= '0;
      ls_q     <= '0;
      rs_q     <= '0;
      lights_q <= decode(POS_C);
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      win_q    <= win_n;
      pos_q    <= pos_n;
      cnt_q    <= cnt_n;
      ls_q     <= ls_n;
      rs_q     <= rs_n;
      lights_q <= (state_n == PLAY) ? decode(pos_n) : '0;
      over_q   <= (state_n == OVER);
    end
  end

  assign lights      = lights_q;
  assign winner      = win_q;
  assign left_score  = ls_q;
  assign right_score = rs_q;
  assign match_over  = over_q;

endmodule
